// File: rtl/pa_clic_arb_scan_pkg.sv
// Shared CLIC arbiter constants and types.
// Key layout, group size and the scan FSM encoding.
package pa_clic_arb_scan_pkg;

    localparam int CLIC_INTNUM     = 64;
    localparam int CLIC_INTCTLBITS = 8;

    localparam int ARB_GRP      = 16;
    localparam int ARB_ID_WIDTH = 12;

    // Compare key {vld, mode, il[7:0], id}, id in the low bits
    localparam int KEY_IL_LSB = ARB_ID_WIDTH;
    localparam int KEY_IL_MSB = KEY_IL_LSB + 7;
    localparam int KEY_MODE   = KEY_IL_MSB + 1;
    localparam int KEY_VLD    = KEY_MODE + 1;
    localparam int KEY_W      = KEY_VLD + 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SCAN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pa_clic_arb_grp.sv
// Combinational maximum over one group of interrupts.
// Ties on {mode, il} go to the higher local index.
module pa_clic_arb_grp
    import pa_clic_arb_scan_pkg::*;
#(
    parameter  int GRP = ARB_GRP,
    localparam int IW  = (GRP > 1) ? $clog2(GRP) : 1
) (
    input  logic [GRP-1:0]   req,
    input  logic [GRP*8-1:0] il,
    input  logic [GRP-1:0]   hv,
    input  logic [GRP-1:0]   mode,
    output logic             vld,
    output logic [IW-1:0]    idx,
    output logic [7:0]       il_max,
    output logic             hv_max,
    output logic             mode_max
);

    // Walk ascending indices; >= lets the later (higher) id win ties
    always_comb begin
        vld      = 1'b0;
        idx      = '0;
        il_max   = '0;
        hv_max   = 1'b0;
        mode_max = 1'b0;
        for (int i = 0; i < GRP; i++) begin
            if (req[i] &&
                ({mode[i], il[8*i +: 8]} >= {mode_max, il_max})) begin
                vld      = 1'b1;
                idx      = IW'(i);
                il_max   = il[8*i +: 8];
                hv_max   = hv[i];
                mode_max = mode[i];
            end
        end
    end

endmodule

// File: rtl/pa_clic_arb_scan.sv
// Multi-cycle CLIC arbiter: one group per cycle, one
// published winner per sweep on the arb_ctrl_* registers.
module pa_clic_arb_scan
    import pa_clic_arb_scan_pkg::*;
#(
    parameter int INTNUM   = CLIC_INTNUM,
    parameter int GRP      = ARB_GRP,
    parameter int ID_WIDTH = ARB_ID_WIDTH
) (
    input  logic                clic_clk,
    input  logic                cpurst_b,
    input  logic [INTNUM-1:0]   kid_arb_int_req,
    input  logic [INTNUM*8-1:0] kid_arb_int_il,
    input  logic [INTNUM-1:0]   kid_arb_int_hv,
    input  logic [INTNUM-1:0]   kid_arb_int_mode,
    input  logic                kid_arb_restart,
    output logic                arb_ctrl_int_req_raw,
    output logic [ID_WIDTH-1:0] arb_ctrl_int_id,
    output logic [7:0]          arb_ctrl_int_il,
    output logic                arb_ctrl_int_hv,
    output logic                arb_ctrl_int_mode
);

    localparam int NGRP = INTNUM / GRP;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int GIW  = (GRP > 1) ? $clog2(GRP) : 1;

    arb_state_e state, state_nxt;
    logic [CW-1:0] grp_cnt, cnt_nxt;

    logic                best_vld;
    logic [ID_WIDTH-1:0] best_id;
    logic [7:0]          best_il;
    logic                best_hv;
    logic                best_mode;

    logic                g_vld;
    logic [GIW-1:0]      g_idx;
    logic [7:0]          g_il;
    logic                g_hv;
    logic                g_mode;
    logic [ID_WIDTH-1:0] g_id;

    logic                m_vld;
    logic [ID_WIDTH-1:0] m_id;
    logic [7:0]          m_il;
    logic                m_hv;
    logic                m_mode;

    logic any_req, first, last, take_g;
    logic best_ld, best_clr, pub_ld, pub_clr;

    assign any_req = |kid_arb_int_req;
    assign first   = (grp_cnt == '0);
    assign last    = (grp_cnt == CW'(NGRP - 1));

    pa_clic_arb_grp #(.GRP(GRP)) u_grp (
        .req      (kid_arb_int_req[grp_cnt*GRP +: GRP]),
        .il       (kid_arb_int_il[grp_cnt*GRP*8 +: GRP*8]),
        .hv       (kid_arb_int_hv[grp_cnt*GRP +: GRP]),
        .mode     (kid_arb_int_mode[grp_cnt*GRP +: GRP]),
        .vld      (g_vld),
        .idx      (g_idx),
        .il_max   (g_il),
        .hv_max   (g_hv),
        .mode_max (g_mode)
    );

    assign g_id = ID_WIDTH'(grp_cnt) * ID_WIDTH'(GRP)
                + ID_WIDTH'(g_idx);

    // The first group discards whatever best was left over
    assign take_g = g_vld &&
                    (first || !best_vld ||
                     ({g_mode, g_il, g_id} >
                      {best_mode, best_il, best_id}));

    // Merge the running best with the current group
    always_comb begin
        m_vld  = 1'b0;
        m_id   = '0;
        m_il   = '0;
        m_hv   = 1'b0;
        m_mode = 1'b0;
        if (take_g) begin
            m_vld  = 1'b1;
            m_id   = g_id;
            m_il   = g_il;
            m_hv   = g_hv;
            m_mode = g_mode;
        end else if (!first && best_vld) begin
            m_vld  = 1'b1;
            m_id   = best_id;
            m_il   = best_il;
            m_hv   = best_hv;
            m_mode = best_mode;
        end
    end

    // Next state, counter and load controls; restart dominates
    always_comb begin
        state_nxt = state;
        cnt_nxt   = grp_cnt;
        best_ld   = 1'b0;
        best_clr  = 1'b0;
        pub_ld    = 1'b0;
        pub_clr   = 1'b0;
        if (kid_arb_restart) begin
            cnt_nxt   = '0;
            best_clr  = 1'b1;
            pub_clr   = 1'b1;
            state_nxt = any_req ? ARB_SCAN : ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        state_nxt = ARB_SCAN;
                        cnt_nxt   = '0;
                    end
                end
                ARB_SCAN: begin
                    if (last) begin
                        pub_ld    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = any_req ? ARB_SCAN : ARB_IDLE;
                    end else begin
                        best_ld = 1'b1;
                        cnt_nxt = grp_cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = ARB_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // FSM state and group counter
    always_ff @(posedge clic_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state   <= ARB_IDLE;
            grp_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grp_cnt <= cnt_nxt;
        end
    end

    // Running best across the groups of one sweep
    always_ff @(posedge clic_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            best_vld  <= 1'b0;
            best_id   <= '0;
            best_il   <= '0;
            best_hv   <= 1'b0;
            best_mode <= 1'b0;
        end else if (best_clr) begin
            best_vld <= 1'b0;
        end else if (best_ld) begin
            best_vld  <= m_vld;
            best_id   <= m_id;
            best_il   <= m_il;
            best_hv   <= m_hv;
            best_mode <= m_mode;
        end
    end

    // Published winner, updated once per completed sweep
    always_ff @(posedge clic_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            arb_ctrl_int_req_raw <= 1'b0;
            arb_ctrl_int_id      <= '0;
            arb_ctrl_int_il      <= '0;
            arb_ctrl_int_hv      <= 1'b0;
            arb_ctrl_int_mode    <= 1'b0;
        end else if (pub_clr) begin
            arb_ctrl_int_req_raw <= 1'b0;
            arb_ctrl_int_id      <= '0;
            arb_ctrl_int_il      <= '0;
            arb_ctrl_int_hv      <= 1'b0;
            arb_ctrl_int_mode    <= 1'b0;
        end else if (pub_ld) begin
            arb_ctrl_int_req_raw <= m_vld;
            arb_ctrl_int_id      <= m_id;
            arb_ctrl_int_il      <= m_il;
            arb_ctrl_int_hv      <= m_hv;
            arb_ctrl_int_mode    <= m_mode;
        end
    end

endmodule

// File: tb/tb_pa_clic_arb_scan.sv
// Bench for pa_clic_arb_scan: directed cases plus random
// request sets checked against a flat argmax model.
module tb_pa_clic_arb_scan;
    import pa_clic_arb_scan_pkg::*;

    localparam int N = 64;

    logic         clic_clk = 1'b0;
    logic         cpurst_b = 1'b1;
    logic [N-1:0] req  = '0;
    logic [N-1:0] hv   = '0;
    logic [N-1:0] mode = '0;
    logic [N*8-1:0] il = '0;
    logic         restart = 1'b0;

    logic        o_req;
    logic [11:0] o_id;
    logic [7:0]  o_il;
    logic        o_hv;
    logic        o_mode;

    int errors = 0;
    int checks = 0;

    pa_clic_arb_scan dut (
        .clic_clk             (clic_clk),
        .cpurst_b             (cpurst_b),
        .kid_arb_int_req      (req),
        .kid_arb_int_il       (il),
        .kid_arb_int_hv       (hv),
        .kid_arb_int_mode     (mode),
        .kid_arb_restart      (restart),
        .arb_ctrl_int_req_raw (o_req),
        .arb_ctrl_int_id      (o_id),
        .arb_ctrl_int_il      (o_il),
        .arb_ctrl_int_hv      (o_hv),
        .arb_ctrl_int_mode    (o_mode)
    );

    always #5 clic_clk = ~clic_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clic_clk);
            #1;
        end
    endtask

    function automatic logic [22:0] obs();
        return {o_req, o_id, o_il, o_hv, o_mode};
    endfunction

    // Winner = pending interrupt with the largest
    // mode*2^20 + il*2^12 + id; nothing pending -> all zero
    function automatic logic [22:0] model();
        int best_k;
        int b;
        int k;
        best_k = -1;
        b = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                k = int'(mode[i]) * 1048576
                  + int'(il[i*8 +: 8]) * 4096 + i;
                if (k > best_k) begin
                    best_k = k;
                    b = i;
                end
            end
        end
        if (best_k < 0) return '0;
        return {1'b1, 12'(b), il[b*8 +: 8], hv[b], mode[b]};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic set_int(input int i, input logic [7:0] l,
                           input logic m, input logic h);
        req[i]        = 1'b1;
        il[i*8 +: 8]  = l;
        mode[i]       = m;
        hv[i]         = h;
    endtask

    task automatic clr_all();
        req  = '0;
        il   = '0;
        mode = '0;
        hv   = '0;
    endtask

    initial begin
        int w;
        #2 cpurst_b = 1'b0;
        tick(2);
        chk("reset_out", 32'(obs()), 32'd0);
        chk("reset_state", 32'(dut.state), 32'(ARB_IDLE));
        cpurst_b = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_out", 32'(obs()), 32'd0);
        end
        chk("idle_state", 32'(dut.state), 32'(ARB_IDLE));

        set_int(37, 8'h80, 1'b1, 1'b1);
        w = 0;
        while (!o_req && w < 9) begin
            tick(1);
            w++;
        end
        chk("id37_latency", 32'(o_req), 32'd1);
        chk("id37", 32'(obs()),
            32'({1'b1, 12'd37, 8'h80, 1'b1, 1'b1}));
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("id37_stable", 32'(obs()), 32'(model()));
        end

        clr_all();
        set_int(5, 8'h60, 1'b1, 1'b0);
        set_int(50, 8'h60, 1'b1, 1'b0);
        tick(10);
        chk("tie_hi_id", 32'(obs()),
            32'({1'b1, 12'd50, 8'h60, 1'b0, 1'b1}));
        il[5*8 +: 8] = 8'h70;
        tick(10);
        chk("lvl_win", 32'(obs()),
            32'({1'b1, 12'd5, 8'h70, 1'b0, 1'b1}));

        clr_all();
        set_int(10, 8'hFF, 1'b0, 1'b1);
        set_int(63, 8'h10, 1'b1, 1'b0);
        tick(10);
        chk("m_beats_u", 32'(obs()),
            32'({1'b1, 12'd63, 8'h10, 1'b0, 1'b1}));

        clr_all();
        set_int(20, 8'h33, 1'b1, 1'b0);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart0", 32'(obs()), 32'd0);
        tick(2);
        chk("restart_cnt", 32'(dut.grp_cnt), 32'd2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_g2", 32'(obs()), 32'd0);
        tick(3);
        chk("restart_early", 32'(obs()), 32'd0);
        tick(1);
        chk("restart_id20", 32'(obs()), 32'(model()));

        clr_all();
        set_int(3, 8'h44, 1'b0, 1'b1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(4);
        chk("id3", 32'(obs()),
            32'({1'b1, 12'd3, 8'h44, 1'b1, 1'b0}));
        clr_all();
        tick(4);
        chk("withdraw_out", 32'(obs()), 32'd0);
        chk("withdraw_state", 32'(dut.state), 32'(ARB_IDLE));

        for (int t = 0; t < 10; t++) begin
            clr_all();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0)
                    set_int(i, 8'($urandom_range(255)),
                            1'($urandom_range(1)),
                            1'($urandom_range(1)));
            end
            set_int($urandom_range(N - 1),
                    8'($urandom_range(255)),
                    1'($urandom_range(1)),
                    1'($urandom_range(1)));
            tick(10);
            chk("rand", 32'(obs()), 32'(model()));
            tick(4);
            chk("rand_next", 32'(obs()), 32'(model()));
        end

        tick(2);
        #2 cpurst_b = 1'b0;
        #1;
        chk("midrst_out", 32'(obs()), 32'd0);
        chk("midrst_state", 32'(dut.state), 32'(ARB_IDLE));
        tick(1);
        cpurst_b = 1'b1;
        tick(10);
        chk("post_rst", 32'(obs()), 32'(model()));

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
